// File: rtl/xor_key_lock_pkg.sv
// Shared types and constants for the XOR key lock.
// Optional feature macro: KEY_PARITY_EN (adds an even-parity bit to the key frame).
package xor_key_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2
    } lock_state_e;

    localparam int LUT_BITS = 4;

    // Frame length: XOR mask bits, then the LUT contents, then the optional parity bit.
    function automatic int key_width(input int n_xor);
`ifdef KEY_PARITY_EN
        return n_xor + LUT_BITS + 1;
`else
        return n_xor + LUT_BITS;
`endif
    endfunction

endpackage

// File: rtl/xor_key_lock_shreg.sv
// Serial key shift register (LSB first) with bit counter and frame-done flag.
module xor_key_lock_shreg #(
    parameter int KEY_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [KEY_W-1:0] key,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    logic [KEY_W-1:0] key_q;
    logic [CNT_W-1:0] cnt_q;

    assign key        = key_q;
    assign frame_done = shift_en & (cnt_q == CNT_W'(KEY_W - 1));

    // Bits enter at the top and move down, so the first bit ends in key[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            key_q <= '0;
            cnt_q <= '0;
        end else if (shift_en) begin
            key_q <= {bit_in, key_q[KEY_W-1:1]};
            if (frame_done) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/xor_key_lock.sv
// Keyed XOR unlock stage with a 4:1 keyed LUT; the key arrives serially.
// Optional feature macro: KEY_PARITY_EN (key frame carries an even-parity bit, key_err reports mismatches).
module xor_key_lock
    import xor_key_lock_pkg::*;
#(
    parameter int N_IN     = 8,
    parameter int N_XOR    = 4,
    parameter int LUT_SEL0 = 0,
    parameter int LUT_SEL1 = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            key_vld,
    input  logic            key_bit,
    output logic            key_rdy,
    input  logic            key_clr,
    output logic            armed,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [N_IN-1:0] din,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [N_IN-1:0] dout,
    output logic            lut_o,
    output logic            key_err
);

    localparam int KEY_W = key_width(N_XOR);

    lock_state_e         state_q;
    lock_state_e         state_d;
    logic [KEY_W-1:0]    key_q;
    logic                frame_done;
    logic                key_accept;
    logic                parity_bad;
    logic                shreg_clr;
    logic                in_accept;
    logic [N_IN-1:0]     mask_ext;
    logic [LUT_BITS-1:0] lut_p;
    logic [1:0]          lut_idx;

    assign key_rdy    = (state_q == ST_IDLE) | (state_q == ST_LOAD);
    assign armed      = (state_q == ST_ARMED);
    assign key_accept = key_vld & key_rdy & ~key_clr;
    assign shreg_clr  = key_clr | parity_bad;

    xor_key_lock_shreg #(
        .KEY_W (KEY_W)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (shreg_clr),
        .shift_en   (key_accept),
        .bit_in     (key_bit),
        .key        (key_q),
        .frame_done (frame_done)
    );

`ifdef KEY_PARITY_EN
    // The frame is even over all KEY_W bits, including the bit arriving now.
    assign parity_bad = frame_done & (^{key_bit, key_q[KEY_W-1:1]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_err <= 1'b0;
        end else if (key_clr) begin
            key_err <= 1'b0;
        end else if (parity_bad) begin
            key_err <= 1'b1;
        end
    end
`else
    assign parity_bad = 1'b0;
    assign key_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_accept) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (frame_done) begin
                    state_d = parity_bad ? ST_IDLE : ST_ARMED;
                end
            end
            ST_ARMED: begin
                state_d = ST_ARMED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (key_clr) begin
            state_d = ST_IDLE;
        end
    end

    // Zero-extend the XOR mask so only din[N_XOR-1:0] is flipped.
    always_comb begin
        mask_ext              = '0;
        mask_ext[N_XOR-1:0]   = key_q[N_XOR-1:0];
        lut_p                 = key_q[N_XOR +: LUT_BITS];
        lut_idx               = {din[LUT_SEL1], din[LUT_SEL0]};
    end

    assign in_rdy    = armed & (~out_vld | out_rdy);
    assign in_accept = in_vld & in_rdy;

    // The stage can only be full while armed; clearing the key flushes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            dout    <= '0;
            lut_o   <= 1'b0;
        end else if (key_clr) begin
            out_vld <= 1'b0;
            dout    <= '0;
            lut_o   <= 1'b0;
        end else if (in_accept) begin
            out_vld <= 1'b1;
            dout    <= din ^ mask_ext;
            lut_o   <= lut_p[lut_idx];
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_key_lock.sv
// Self-checking bench for xor_key_lock: directed scenarios plus random traffic against a queue-based model.
module tb_xor_key_lock;
    import xor_key_lock_pkg::*;

    localparam int N_IN  = 8;
    localparam int N_XOR = 4;
    localparam int KEY_W = key_width(N_XOR);
`ifdef KEY_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            key_vld = 1'b0;
    logic            key_bit = 1'b0;
    logic            key_rdy;
    logic            key_clr = 1'b0;
    logic            armed;
    logic            in_vld = 1'b0;
    logic            in_rdy;
    logic [N_IN-1:0] din = '0;
    logic            out_vld;
    logic            out_rdy = 1'b0;
    logic [N_IN-1:0] dout;
    logic            lut_o;
    logic            key_err;

    int err_cnt = 0;
    int chk_cnt = 0;
    bit checks_on = 1'b1;

    xor_key_lock #(
        .N_IN     (N_IN),
        .N_XOR    (N_XOR),
        .LUT_SEL0 (0),
        .LUT_SEL1 (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_vld (key_vld),
        .key_bit (key_bit),
        .key_rdy (key_rdy),
        .key_clr (key_clr),
        .armed   (armed),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .din     (din),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .dout    (dout),
        .lut_o   (lut_o),
        .key_err (key_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the key is just the list of accepted bits; it arms once KEY_W bits are in.
    int              m_q[$];
    bit              m_armed = 1'b0;
    bit              m_out_vld = 1'b0;
    bit              m_lut = 1'b0;
    bit              m_err = 1'b0;
    logic [N_IN-1:0] m_dout = '0;
    int              m_key = 0;
    int              m_par, m_xm, m_p, m_idx;
    bit              m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_armed = 0; m_out_vld = 0; m_lut = 0; m_err = 0; m_dout = '0; m_key = 0;
        end else begin
            m_acc = in_vld && m_armed && (!m_out_vld || out_rdy);
            if (key_clr) begin
                m_q.delete();
                m_armed = 0; m_out_vld = 0; m_lut = 0; m_err = 0; m_dout = '0; m_key = 0;
            end else begin
                if (m_acc) begin
                    m_xm      = m_key % (1 << N_XOR);
                    m_p       = (m_key >> N_XOR) % 16;
                    m_idx     = 2 * int'(din[1]) + int'(din[0]);
                    m_dout    = din ^ N_IN'(m_xm);
                    m_lut     = ((m_p >> m_idx) & 1) == 1;
                    m_out_vld = 1;
                end else if (out_rdy) begin
                    m_out_vld = 0;
                end
                if (key_vld && !m_armed) begin
                    m_q.push_back(int'(key_bit));
                    if (m_q.size() == KEY_W) begin
                        m_par = 0;
                        m_key = 0;
                        foreach (m_q[i]) begin
                            m_par ^= m_q[i];
                            m_key += m_q[i] << i;
                        end
                        if (PARITY && m_par != 0) begin
                            m_err = 1;
                            m_key = 0;
                            m_q.delete();
                        end else begin
                            m_armed = 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checks_on) begin
            check_output("key_rdy", key_rdy, !m_armed);
            check_output("armed", armed, m_armed);
            check_output("in_rdy", in_rdy, m_armed && (!m_out_vld || out_rdy));
            check_output("out_vld", out_vld, m_out_vld);
            check_output("dout", dout, m_dout);
            check_output("lut_o", lut_o, m_lut);
            check_output("key_err", key_err, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] make_frame(input logic [7:0] k, input bit good);
        logic [31:0] f;
        f = {24'd0, k};
        if (PARITY) f[8] = (^k) ^ !good;
        return f;
    endfunction

    task automatic send_bits(input logic [31:0] frame, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            key_vld = 1'b1;
            key_bit = frame[i];
            step();
        end
        key_vld = 1'b0;
    endtask

    task automatic apply_stimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            key_vld = $urandom_range(0, 1) == 1;
            key_bit = $urandom_range(0, 1) == 1;
            key_clr = $urandom_range(0, 39) == 0;
            in_vld  = $urandom_range(0, 1) == 1;
            din     = N_IN'($urandom);
            out_rdy = $urandom_range(0, 3) != 0;
            rst_n   = $urandom_range(0, 299) != 0;
            step();
        end
        rst_n = 1'b1;
        key_vld = 0; key_clr = 0; in_vld = 0; out_rdy = 0;
    endtask

    logic [31:0] frame;

    initial begin
        frame = make_frame(8'b1010_0110, 1'b1);
        step();
        step();
        at_neg();
        check_output("reset_armed", armed, 1'b0);
        check_output("reset_out_vld", out_vld, 1'b0);
        check_output("reset_dout", dout, 8'h00);
        check_output("reset_key_rdy", key_rdy, 1'b1);
        rst_n = 1'b1;
        step();

        // Pre-arm traffic must be refused.
        in_vld = 1'b1;
        din    = 8'hAA;
        send_bits(frame, 0, KEY_W - 2);
        at_neg();
        check_output("prearm_in_rdy", in_rdy, 1'b0);
        check_output("prearm_out_vld", out_vld, 1'b0);
        check_output("prearm_dout", dout, 8'h00);
        in_vld = 1'b0;
        send_bits(frame, KEY_W - 1, KEY_W - 1);
        at_neg();
        check_output("key_armed", armed, 1'b1);
        check_output("key_rdy_armed", key_rdy, 1'b0);
        check_output("model_key", m_key, 32'hA6);

        in_vld  = 1'b1;
        din     = 8'h5B;
        out_rdy = 1'b0;
        #1;
        check_output("dp_in_rdy", in_rdy, 1'b1);
        step();
        in_vld = 1'b0;
        at_neg();
        check_output("dp_dout", dout, 8'h5D);
        check_output("dp_lut", lut_o, 1'b1);
        check_output("dp_out_vld", out_vld, 1'b1);
        check_output("dp_in_rdy_full", in_rdy, 1'b0);
        check_output("model_dout", m_dout, 8'h5D);
        in_vld = 1'b1;
        din    = 8'hFF;
        step();
        step();
        at_neg();
        check_output("dp_hold_dout", dout, 8'h5D);
        check_output("dp_hold_in_rdy", in_rdy, 1'b0);

        in_vld  = 1'b0;
        key_vld = 1'b1;
        key_bit = 1'b1;
        key_clr = 1'b1;
        step();
        key_clr = 1'b0;
        key_vld = 1'b0;
        at_neg();
        check_output("clr_out_vld", out_vld, 1'b0);
        check_output("clr_armed", armed, 1'b0);
        check_output("clr_key_rdy", key_rdy, 1'b1);
        check_output("clr_shreg", dut.u_shreg.key_q, 32'h0);
        check_output("clr_cnt", dut.u_shreg.cnt_q, 32'h0);

        step();
        send_bits(frame, 0, 2);
        rst_n = 1'b0;
        at_neg();
        check_output("rst_armed", armed, 1'b0);
        check_output("rst_out_vld", out_vld, 1'b0);
        check_output("rst_dout", dout, 8'h00);
        check_output("rst_lut", lut_o, 1'b0);
        check_output("rst_shreg", dut.u_shreg.key_q, 32'h0);
        step();
        rst_n = 1'b1;
        send_bits(frame, 0, KEY_W - 2);
        at_neg();
        check_output("reload_not_armed", armed, 1'b0);
        send_bits(frame, KEY_W - 1, KEY_W - 1);
        at_neg();
        check_output("reload_armed", armed, 1'b1);

`ifdef KEY_PARITY_EN
        key_clr = 1'b1;
        step();
        key_clr = 1'b0;
        send_bits(make_frame(8'b1010_0110, 1'b0), 0, KEY_W - 1);
        at_neg();
        check_output("par_bad_err", key_err, 1'b1);
        check_output("par_bad_armed", armed, 1'b0);
        key_clr = 1'b1;
        step();
        key_clr = 1'b0;
        at_neg();
        check_output("par_clr_err", key_err, 1'b0);
        send_bits(frame, 0, KEY_W - 1);
        at_neg();
        check_output("par_good_armed", armed, 1'b1);
        check_output("par_good_err", key_err, 1'b0);
`endif

        apply_stimulus(2500);
        step();
        checks_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
